// File: rtl/program_loader.sv
// Framed byte-stream boot loader: parses sync/address/length/payload/checksum,
// writes payload bytes into program memory and holds the core in reset until a good frame lands.
module program_loader #(
    parameter int MAX_BYTES    = 4096,
    parameter int IDLE_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic [31:0] write_address,
    output logic [7:0]  write_data,
    output logic        write_enable,
    output logic        cpu_reset_n,
    output logic        load_busy,
    output logic        load_done,
    output logic        load_error,
    output logic [1:0]  error_code
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_LEN, S_PAYLOAD, S_CHECK, S_DONE, S_ERROR
    } state_t;

    localparam logic [7:0]  SYNC_BYTE  = 8'hA5;
    localparam logic [31:0] LEN_LIMIT  = 32'(MAX_BYTES);
    localparam logic [31:0] TIMER_LAST = 32'(IDLE_TIMEOUT - 1);

    state_t      r_state, w_state_next;
    logic        r_rx_ready;
    logic [1:0]  r_hdr_cnt, w_hdr_cnt_next;
    logic [31:0] r_addr, w_addr_next;
    logic [31:0] r_len, w_len_next;
    logic [31:0] r_idx, w_idx_next;
    logic [7:0]  r_sum, w_sum_next;
    logic [31:0] r_timer, w_timer_next;
    logic [1:0]  r_err_code, w_err_code_next;
    logic        r_we, w_we_next;
    logic [31:0] r_waddr, w_waddr_next;
    logic [7:0]  r_wdata, w_wdata_next;

    logic        w_accept;
    logic        w_in_frame;
    logic [31:0] w_len_full;

    assign w_accept   = rx_valid & r_rx_ready;
    assign w_in_frame = (r_state == S_ADDR) || (r_state == S_LEN) ||
                        (r_state == S_PAYLOAD) || (r_state == S_CHECK);
    // Header fields arrive little-endian, so each new byte shifts in from the top.
    assign w_len_full = {rx_data, r_len[31:8]};

    always_comb begin
        w_state_next    = r_state;
        w_hdr_cnt_next  = r_hdr_cnt;
        w_addr_next     = r_addr;
        w_len_next      = r_len;
        w_idx_next      = r_idx;
        w_sum_next      = r_sum;
        w_timer_next    = r_timer;
        w_err_code_next = r_err_code;
        w_we_next       = 1'b0;
        w_waddr_next    = r_waddr;
        w_wdata_next    = r_wdata;

        unique case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (w_accept && rx_data == SYNC_BYTE) begin
                    w_state_next    = S_ADDR;
                    w_hdr_cnt_next  = 2'd0;
                    w_err_code_next = 2'b00;
                    w_timer_next    = 32'd0;
                    w_sum_next      = 8'd0;
                    w_idx_next      = 32'd0;
                end
            end
            S_ADDR: begin
                if (w_accept) begin
                    w_addr_next    = {rx_data, r_addr[31:8]};
                    w_hdr_cnt_next = r_hdr_cnt + 2'd1;
                    if (r_hdr_cnt == 2'd3) begin
                        w_state_next = S_LEN;
                    end
                end
            end
            S_LEN: begin
                if (w_accept) begin
                    w_len_next     = w_len_full;
                    w_hdr_cnt_next = r_hdr_cnt + 2'd1;
                    if (r_hdr_cnt == 2'd3) begin
                        if (w_len_full > LEN_LIMIT) begin
                            w_state_next    = S_ERROR;
                            w_err_code_next = 2'b01;
                        end else if (w_len_full == 32'd0) begin
                            w_state_next = S_CHECK;
                        end else begin
                            w_state_next = S_PAYLOAD;
                        end
                    end
                end
            end
            S_PAYLOAD: begin
                if (w_accept) begin
                    w_we_next    = 1'b1;
                    w_waddr_next = r_addr + r_idx;
                    w_wdata_next = rx_data;
                    w_sum_next   = r_sum + rx_data;
                    w_idx_next   = r_idx + 32'd1;
                    if (r_idx == r_len - 32'd1) begin
                        w_state_next = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (w_accept) begin
                    if (rx_data == r_sum) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next    = S_ERROR;
                        w_err_code_next = 2'b10;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        // Idle watchdog only runs inside a frame; any accepted byte restarts it.
        if (w_in_frame) begin
            if (w_accept) begin
                w_timer_next = 32'd0;
            end else if (r_timer == TIMER_LAST) begin
                w_state_next    = S_ERROR;
                w_err_code_next = 2'b11;
            end else begin
                w_timer_next = r_timer + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_rx_ready <= 1'b0;
            r_hdr_cnt  <= 2'd0;
            r_addr     <= 32'd0;
            r_len      <= 32'd0;
            r_idx      <= 32'd0;
            r_sum      <= 8'd0;
            r_timer    <= 32'd0;
            r_err_code <= 2'b00;
            r_we       <= 1'b0;
            r_waddr    <= 32'd0;
            r_wdata    <= 8'd0;
        end else begin
            r_state    <= w_state_next;
            r_rx_ready <= 1'b1;
            r_hdr_cnt  <= w_hdr_cnt_next;
            r_addr     <= w_addr_next;
            r_len      <= w_len_next;
            r_idx      <= w_idx_next;
            r_sum      <= w_sum_next;
            r_timer    <= w_timer_next;
            r_err_code <= w_err_code_next;
            r_we       <= w_we_next;
            r_waddr    <= w_waddr_next;
            r_wdata    <= w_wdata_next;
        end
    end

    assign rx_ready      = r_rx_ready;
    assign write_enable  = r_we;
    assign write_address = r_waddr;
    assign write_data    = r_wdata;
    assign cpu_reset_n   = (r_state == S_DONE);
    assign load_busy     = w_in_frame;
    assign load_done     = (r_state == S_DONE);
    assign load_error    = (r_state == S_ERROR);
    assign error_code    = r_err_code;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: expected memory writes go into a scoreboard queue
// as payload is driven and are popped by a monitor when write_enable strobes.
module tb_program_loader;

    localparam int MAX_BYTES    = 4096;
    localparam int IDLE_TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [31:0] write_address;
    logic [7:0]  write_data;
    logic        write_enable;
    logic        cpu_reset_n;
    logic        load_busy;
    logic        load_done;
    logic        load_error;
    logic [1:0]  error_code;

    program_loader #(
        .MAX_BYTES    (MAX_BYTES),
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .rx_ready      (rx_ready),
        .write_address (write_address),
        .write_data    (write_data),
        .write_enable  (write_enable),
        .cpu_reset_n   (cpu_reset_n),
        .load_busy     (load_busy),
        .load_done     (load_done),
        .load_error    (load_error),
        .error_code    (error_code)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [39:0] sb[$];
    logic [7:0]  pay[8];
    logic [7:0]  exp_sum;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (write_enable === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {24'd0, write_address, write_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                logic [39:0] e;
                e = sb.pop_front();
                check("write", {24'd0, write_address, write_data}, {24'd0, e});
                $display("write addr=%08h data=%02h expected addr=%08h data=%02h",
                         write_address, write_data, e[39:8], e[7:0]);
            end
        end
    end

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_header(input logic [31:0] addr, input logic [31:0] len);
        send(8'hA5);
        check("sync_busy", 64'(load_busy), 64'd1);
        check("sync_core_held", 64'(cpu_reset_n), 64'd0);
        check("sync_clears_done", 64'({load_done, load_error, error_code}), 64'd0);
        for (int i = 0; i < 4; i++) send(addr[8*i +: 8]);
        for (int i = 0; i < 4; i++) send(len[8*i +: 8]);
    endtask

    task automatic send_payload(input logic [31:0] addr, input int n);
        exp_sum = 8'd0;
        for (int i = 0; i < n; i++) begin
            sb.push_back({addr + 32'(i), pay[i]});
            exp_sum = exp_sum + pay[i];
            send(pay[i]);
        end
    endtask

    task automatic check_result(input string tag, input logic done, input logic [1:0] code);
        $display("frame %s: done=%0b error=%0b code=%0d core_run=%0b", tag, load_done, load_error,
                 error_code, cpu_reset_n);
        check({tag, "_done"}, 64'(load_done), 64'(done));
        check({tag, "_error"}, 64'(load_error), 64'(!done));
        check({tag, "_code"}, 64'(error_code), 64'(code));
        check({tag, "_core"}, 64'(cpu_reset_n), 64'(done));
        check({tag, "_busy"}, 64'(load_busy), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, {27'd0, rx_ready, write_enable, write_address, write_data, cpu_reset_n,
                    load_busy, load_done, load_error, error_code}, 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_values");
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rx_ready_after_reset", 64'(rx_ready), 64'd1);
        check("idle_core_held", 64'(cpu_reset_n), 64'd0);

        // Basic load
        pay[0] = 8'h13; pay[1] = 8'h00; pay[2] = 8'h00; pay[3] = 8'h00;
        send_header(32'h0, 32'd4);
        send_payload(32'h0, 4);
        send(exp_sum);
        check_result("basic", 1'b1, 2'b00);

        // Bad checksum
        send_header(32'h0, 32'd4);
        send_payload(32'h0, 4);
        send(exp_sum + 8'd1);
        check_result("bad_csum", 1'b0, 2'b10);

        // Oversize length: error right after the 4th length byte, no writes
        send_header(32'h0, 32'h0100_1000);
        check_result("oversize", 1'b0, 2'b01);
        // Exactly MAX_BYTES is legal: header lands in PAYLOAD and stays busy
        send_header(32'h0, 32'(MAX_BYTES));
        check("max_len_busy", 64'(load_busy), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Zero length
        send_header(32'h0000_0100, 32'd0);
        send(8'h00);
        check_result("zero_len", 1'b1, 2'b00);

        // Address wrap
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        send_header(32'hFFFF_FFFE, 32'd3);
        send_payload(32'hFFFF_FFFE, 3);
        send(exp_sum);
        check_result("wrap", 1'b1, 2'b00);

        // Timeout after 2nd address byte
        send(8'hA5);
        send(8'h00);
        send(8'h00);
        repeat (IDLE_TIMEOUT - 1) @(posedge clk);
        #1;
        check("timeout_not_yet", 64'(load_busy), 64'd1);
        @(posedge clk);
        #1;
        check_result("timeout", 1'b0, 2'b11);
        send(8'h00);
        send(8'hFF);
        check_result("junk_ignored", 1'b0, 2'b11);
        pay[0] = 8'hDE; pay[1] = 8'hAD;
        send_header(32'h0000_2000, 32'd2);
        send_payload(32'h0000_2000, 2);
        send(exp_sum);
        check_result("resync", 1'b1, 2'b00);

        // Reset mid-payload after 2 of 4 bytes
        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03; pay[3] = 8'h04;
        send_header(32'h0000_0040, 32'd4);
        send_payload(32'h0000_0040, 2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("mid_reset_values");
        reset = 1'b0;
        @(posedge clk);
        #1;
        send_header(32'h0000_0040, 32'd4);
        send_payload(32'h0000_0040, 4);
        send(exp_sum);
        check_result("after_reset", 1'b1, 2'b00);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
